mult_unit: RTL

- Multi-cycle multiplier executing MIPS MULT/MULTU into the HI/LO register pair.
- It is the companion of the divide unit: it performs the inverse arithmetic, and it shares the same operand, sign-control and HI/LO result interface.
- It is a radix-2 shift-add engine running one partial product per clock. Operand signs are handled by magnitude conversion on entry and negation on exit.
- The pipeline stalls on busy and writes hi/lo to the HI/LO registers on done.

---
 rtl/mult_unit.sv | 122 ++++++++++++
 1 files changed

// File: rtl/mult_unit.sv
// Radix-2 shift-add MULT/MULTU engine producing a 2*WIDTH product into hi/lo.
// Signed operands are reduced to magnitudes on entry and the product is negated on exit.
module mult_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signmult,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      count_q, count_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic               neg_q, neg_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               sa, sb;
    logic [WIDTH:0]     sum;

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
        return ~x + WIDTH'(1);
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
        return ~x + (2*WIDTH)'(1);
    endfunction

    // Upper half of prod_q is the running partial sum; lower half is the multiplier being shifted out.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        prod_d  = prod_q;
        mcand_d = mcand_q;
        neg_d   = neg_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        hi_d    = hi_q;
        lo_d    = lo_q;
        sa      = signmult & a[WIDTH-1];
        sb      = signmult & b[WIDTH-1];
        sum     = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
                + ({1'b0, mcand_q} & {(WIDTH+1){prod_q[0]}});

        case (state_q)
            S_IDLE: begin
                // The done cycle still counts as busy, so a start there is dropped.
                if (done_q) begin
                    busy_d = 1'b0;
                end else if (start) begin
                    mcand_d = sa ? neg_w(a) : a;
                    prod_d  = {{WIDTH{1'b0}}, (sb ? neg_w(b) : b)};
                    neg_d   = sa ^ sb;
                    count_d = '0;
                    busy_d  = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                prod_d  = {sum, prod_q[WIDTH-1:1]};
                count_d = count_q + CW'(1);
                if (count_q == CW'(WIDTH-1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                {hi_d, lo_d} = neg_q ? neg_2w(prod_q) : prod_q;
                done_d       = 1'b1;
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            count_q <= '0;
            prod_q  <= '0;
            mcand_q <= '0;
            neg_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            prod_q  <= prod_d;
            mcand_q <= mcand_d;
            neg_q   <= neg_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
